// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiters: FSM state encoding and the
// requester-id width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    function automatic int id_width(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after rr_ptr,
// wrapping modulo NREQ, as both a one-hot grant and an index.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            found
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                winner     = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_unit_arbiter.sv
// Shares one external combinational XOR unit between NREQ requesters: grant,
// register operands, capture the result a cycle later, then hold it until accepted.
module xor_unit_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      alu_in1,
    output logic [WIDTH-1:0]      alu_in2,
    input  logic [WIDTH-1:0]      alu_out,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    input  logic                  rsp_ready,
    output logic                  busy
);

    // Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i];
    // a response transfers in the cycle rsp_valid && rsp_ready, and rsp_* stay
    // stable while rsp_valid is high and rsp_ready is low.

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]      alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0]      alu_in2_q, alu_in2_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]       pick_grant;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_found;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .winner    (pick_idx),
        .found     (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    alu_in1_d = req_a[int'(pick_idx)*WIDTH +: WIDTH];
                    alu_in2_d = req_b[int'(pick_idx)*WIDTH +: WIDTH];
                    rsp_id_d  = pick_idx;
                    rr_ptr_d  = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Grant is combinational; gating with rst_n keeps it low while reset is held.
    assign req_ready = (rst_n && state_q == IDLE) ? pick_grant : '0;
    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter with a behavioural XOR unit on the ALU port.
module tb_xor_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 2;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      alu_in1;
    logic [WIDTH-1:0]      alu_in2;
    logic [WIDTH-1:0]      alu_out;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_ready;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    xor_unit_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // External shared XOR unit
    assign alu_out = alu_in1 ^ alu_in2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [NREQ-1:0]       valid;
        logic [NREQ*WIDTH-1:0] a;
        logic [NREQ*WIDTH-1:0] b;
        logic [NREQ-1:0]       exp_ready;
        logic [IDW-1:0]        exp_id;
        logic [WIDTH-1:0]      exp_data;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_alu_in1"},   32'(alu_in1),   0);
        check({tag, "_alu_in2"},   32'(alu_in2),   0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_id"},    32'(rsp_id),    0);
        check({tag, "_rsp_data"},  32'(rsp_data),  0);
        check({tag, "_busy"},      32'(busy),      0);
    endtask

    // One full grant/issue/hold/accept transaction with requests held throughout.
    task automatic run_op(input vec_t v, input string tag);
        logic [WIDTH-1:0] ea, eb;
        ea = v.a[int'(v.exp_id)*WIDTH +: WIDTH];
        eb = v.b[int'(v.exp_id)*WIDTH +: WIDTH];
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(v.exp_ready));
        step();
        check({tag, "_issue_busy"},  32'(busy),      1);
        check({tag, "_issue_ready"}, 32'(req_ready), 0);
        check({tag, "_issue_rspv"},  32'(rsp_valid), 0);
        check({tag, "_alu_in1"},     32'(alu_in1),   32'(ea));
        check({tag, "_alu_in2"},     32'(alu_in2),   32'(eb));
        step();
        check({tag, "_hold_rspv"},  32'(rsp_valid), 1);
        check({tag, "_hold_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_id"},     32'(rsp_id),    32'(v.exp_id));
        check({tag, "_rsp_data"},   32'(rsp_data),  32'(v.exp_data));
        req_valid = '0;
        step();
        check({tag, "_done_rspv"}, 32'(rsp_valid), 0);
        check({tag, "_done_busy"}, 32'(busy),      0);
    endtask

    initial begin
        logic [NREQ*WIDTH-1:0] ta, tb;
        vec_t v;
        logic [WIDTH-1:0] hold_data;
        logic [IDW-1:0]   hold_id;

        // a0..a3 = 0,1,2,3 ; b0..b3 = 2,0,3,1 ; a^b = 2,1,1,2
        ta = 8'b11_10_01_00;
        tb = 8'b01_11_00_10;
        vecs[0]  = '{4'b1111, ta, tb, 4'b0001, 2'd0, 2'b10};
        vecs[1]  = '{4'b1111, ta, tb, 4'b0010, 2'd1, 2'b01};
        vecs[2]  = '{4'b1111, ta, tb, 4'b0100, 2'd2, 2'b01};
        vecs[3]  = '{4'b1111, ta, tb, 4'b1000, 2'd3, 2'b10};
        vecs[4]  = '{4'b1111, ta, tb, 4'b0001, 2'd0, 2'b10};
        vecs[5]  = '{4'b0100, ta, tb, 4'b0100, 2'd2, 2'b01};
        vecs[6]  = '{4'b0101, ta, tb, 4'b0001, 2'd0, 2'b10};
        vecs[7]  = '{4'b0101, ta, tb, 4'b0100, 2'd2, 2'b01};
        vecs[8]  = '{4'b1000, ta, tb, 4'b1000, 2'd3, 2'b10};
        vecs[9]  = '{4'b0110, ta, tb, 4'b0010, 2'd1, 2'b01};
        vecs[10] = '{4'b0110, ta, tb, 4'b0100, 2'd2, 2'b01};

        // Reset with every requester asserting
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = ta;
        req_b     = tb;
        rsp_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("post_reset_grant", 32'(req_ready), 32'(4'b0001));

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure in HOLD; rr_ptr is 3 here, only req 1 asks
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant", 32'(req_ready), 32'(4'b0010));
        step();
        step();
        check("bp_rspv", 32'(rsp_valid), 1);
        check("bp_data", 32'(rsp_data), 32'(2'b01));
        hold_data = rsp_data;
        hold_id   = rsp_id;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_stall_rspv",  32'(rsp_valid), 1);
            check("bp_stall_data",  32'(rsp_data),  32'(hold_data));
            check("bp_stall_id",    32'(rsp_id),    32'(hold_id));
            check("bp_stall_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        check("bp_release_rspv", 32'(rsp_valid), 0);
        check("bp_release_busy", 32'(busy),      0);

        // Reset while the operation sits in ISSUE
        req_valid = 4'b0010;
        req_a     = 8'b00_00_01_00;
        req_b     = 8'b00_00_00_00;
        step();
        check("abort_in_issue", 32'(busy), 1);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("abort_no_rsp", 32'(rsp_valid), 0);
        end

        // Exhaustive operand sweep on requester 1
        for (int p = 0; p < 16; p++) begin
            logic [WIDTH-1:0] a1, b1;
            a1 = WIDTH'(p >> 2);
            b1 = WIDTH'(p & 3);
            v.valid     = 4'b0010;
            v.a         = {4'b0000, a1, 2'b00};
            v.b         = {4'b0000, b1, 2'b00};
            v.exp_ready = 4'b0010;
            v.exp_id    = 2'd1;
            v.exp_data  = a1 ^ b1;
            run_op(v, $sformatf("sweep%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
